// File: rtl/joy_pkg.sv
// Shared types and constants for the serial joystick scan controller.
// Bit positions describe the default 24-bit board chain (active-low buttons).
package joy_pkg;

    typedef enum logic [1:0] {
        ST_LOAD   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_SHIFT  = 2'd2
    } scan_state_t;

    localparam int JOY_P1_START  = 0;
    localparam int JOY_P1_FIRE3  = 1;
    localparam int JOY_P1_FIRE2  = 2;
    localparam int JOY_P1_FIRE1  = 3;
    localparam int JOY_P1_RIGHT  = 4;
    localparam int JOY_P1_LEFT   = 5;
    localparam int JOY_P1_DOWN   = 6;
    localparam int JOY_P1_UP     = 7;
    localparam int JOY_P2_START  = 8;
    localparam int JOY_P2_FIRE3  = 9;
    localparam int JOY_P2_FIRE2  = 10;
    localparam int JOY_P2_FIRE1  = 11;
    localparam int JOY_P2_RIGHT  = 12;
    localparam int JOY_P2_LEFT   = 13;
    localparam int JOY_P2_DOWN   = 14;
    localparam int JOY_P2_UP     = 15;
    localparam int JOY_P2_SELECT = 16;
    localparam int JOY_TEST      = 17;
    localparam int JOY_P2_COIN   = 18;
    localparam int JOY_P2_FIRE4  = 19;
    localparam int JOY_P1_SELECT = 20;
    localparam int JOY_SERVICE   = 21;
    localparam int JOY_P1_COIN   = 22;
    localparam int JOY_P1_FIRE4  = 23;

    // Width of a bit index into an n-bit word, never narrower than one bit.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/joy_tick_gen.sv
// Free-running divider: one-cycle tick every 2^DIV_LOG2 clocks plus the
// counter MSB as a half-period phase for the chain shift clock.
module joy_tick_gen #(
    parameter int DIV_LOG2 = 3
) (
    input  logic clk,
    input  logic rst,
    output logic tick,
    output logic phase
);

    logic [DIV_LOG2-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + DIV_LOG2'(1);
        end
    end

    assign tick  = &cnt;
    assign phase = cnt[DIV_LOG2-1];

endmodule

// File: rtl/joy_scan_ctrl.sv
// Sequenced scan of the serial joystick chain with frame-aligned snapshot publish.
// Optional JOY_DEBOUNCE_EN: a scan reaches the shadow only if it matches the previous scan.
module joy_scan_ctrl
    import joy_pkg::*;
#(
    parameter int DIV_LOG2 = 3,
    parameter int NBITS    = 24
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             joy_data,
    output logic             joy_load,
    output logic             joy_clk,
    input  logic             snap_req,
    output logic [NBITS-1:0] joy_state,
    output logic             joy_valid,
    output logic             scan_done
);

    localparam int IDX_W = idx_width(NBITS);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NBITS - 1);

    logic             tick;
    logic             phase;
    scan_state_t      state;
    scan_state_t      state_next;
    logic [IDX_W-1:0] bit_idx;
    logic             last_bit;
    logic             sample;
    logic [NBITS-1:0] raw;
    logic [NBITS-1:0] shadow;
    logic             shadow_valid;
    logic             accept;
    logic [NBITS-1:0] shadow_view;
    logic             view_valid;
    logic             pending;
    logic             want;

    joy_tick_gen #(
        .DIV_LOG2(DIV_LOG2)
    ) u_tick (
        .clk   (clk),
        .rst   (rst),
        .tick  (tick),
        .phase (phase)
    );

    assign last_bit = (bit_idx == LAST_IDX);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_LOAD;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        joy_load   = 1'b1;
        joy_clk    = 1'b0;
        sample     = 1'b0;
        case (state)
            ST_LOAD: begin
                joy_load = 1'b0;
                if (tick) state_next = ST_SETTLE;
            end
            ST_SETTLE: begin
                if (tick) state_next = ST_SHIFT;
            end
            ST_SHIFT: begin
                joy_clk = phase;
                sample  = tick;
                if (tick && last_bit) state_next = ST_LOAD;
            end
            default: state_next = ST_LOAD;
        endcase
    end

    // raw is only consumed in the scan_done cycle, when it holds one whole scan.
    always_ff @(posedge clk) begin
        if (rst) begin
            bit_idx   <= '0;
            raw       <= '1;
            scan_done <= 1'b0;
        end else begin
            scan_done <= sample && last_bit;
            if (sample) begin
                raw[bit_idx] <= joy_data;
                bit_idx      <= last_bit ? '0 : bit_idx + IDX_W'(1);
            end
        end
    end

`ifdef JOY_DEBOUNCE_EN
    logic [NBITS-1:0] prev_raw;
    logic             prev_valid;

    always_ff @(posedge clk) begin
        if (rst) begin
            prev_raw   <= '1;
            prev_valid <= 1'b0;
        end else if (scan_done) begin
            prev_raw   <= raw;
            prev_valid <= 1'b1;
        end
    end

    assign accept = scan_done && prev_valid && (raw == prev_raw);
`else
    assign accept = scan_done;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            shadow       <= '1;
            shadow_valid <= 1'b0;
        end else if (accept) begin
            shadow       <= raw;
            shadow_valid <= 1'b1;
        end
    end

    // A request coinciding with an accepted scan must see that scan, so bypass the shadow.
    assign shadow_view = accept ? raw : shadow;
    assign view_valid  = accept || shadow_valid;
    assign want        = pending || snap_req;

    always_ff @(posedge clk) begin
        if (rst) begin
            joy_state <= '1;
            joy_valid <= 1'b0;
            pending   <= 1'b0;
        end else begin
            pending <= want && !view_valid;
            if (want && view_valid) begin
                joy_state <= shadow_view;
                joy_valid <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_joy_scan_ctrl.sv
// Self-checking bench for joy_scan_ctrl: chain model, cycle-level reference, vector table.
// Build with +define+JOY_DEBOUNCE_EN to exercise the debounce configuration.
module tb_joy_scan_ctrl;

    localparam int DIV_LOG2 = 3;
    localparam int NBITS    = 24;
    localparam int TICK     = 1 << DIV_LOG2;
    localparam int PER      = (NBITS + 2) * TICK;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             joy_data = 1'b1;
    logic             snap_req = 1'b0;
    logic             joy_load;
    logic             joy_clk;
    logic [NBITS-1:0] joy_state;
    logic             joy_valid;
    logic             scan_done;

    int n_checks = 0;
    int n_errors = 0;

    // Parallel word presented by the joystick chain model.
    logic [NBITS-1:0] word      = '1;
    logic [NBITS-1:0] chain_reg = '1;
    int               chain_idx = 0;
    logic             prev_clk  = 1'b0;

    // Reference model: time since reset, scan word latched, and publish bookkeeping.
    int               m_c;
    logic [NBITS-1:0] m_scan_word;
    logic [NBITS-1:0] m_shadow;
    logic             m_shadow_valid;
    logic [NBITS-1:0] m_prev;
    logic             m_prev_valid;
    logic             m_pending;
    logic [NBITS-1:0] m_state;
    logic             m_valid;

    typedef struct {
        logic [NBITS-1:0] word;
        int               snap_a;
        int               snap_b;
        logic [NBITS-1:0] exp_state;
        logic             exp_valid;
    } vec_t;

    vec_t vecs[10];

    always #5 clk = ~clk;

    joy_scan_ctrl #(
        .DIV_LOG2 (DIV_LOG2),
        .NBITS    (NBITS)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .joy_data  (joy_data),
        .joy_load  (joy_load),
        .joy_clk   (joy_clk),
        .snap_req  (snap_req),
        .joy_state (joy_state),
        .joy_valid (joy_valid),
        .scan_done (scan_done)
    );

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_errors++;
            $display("[TB] FAIL %s: actual=%h required=%h", name, actual, expected);
        end
    endtask

    task automatic resetModel();
        m_c            = 0;
        m_scan_word    = '1;
        m_shadow       = '1;
        m_shadow_valid = 1'b0;
        m_prev         = '1;
        m_prev_valid   = 1'b0;
        m_pending      = 1'b0;
        m_state        = '1;
        m_valid        = 1'b0;
    endtask

    // Called at a falling edge: check this cycle, drive inputs for the next rising edge.
    task automatic applyStimulus(input logic snap_in, input logic rst_in);
        int   ph;
        logic exp_load;
        logic exp_clk;
        logic exp_done;
        ph       = m_c % PER;
        exp_load = (ph >= TICK);
        exp_clk  = (ph >= 2 * TICK) && ((ph % TICK) >= TICK / 2);
        exp_done = (m_c >= PER) && (ph == 0);
        checkOutput($sformatf("cycle_outputs c=%0d", m_c),
                    {4'd0, joy_load, joy_clk, scan_done, joy_valid, joy_state},
                    {4'd0, exp_load, exp_clk, exp_done, m_valid, m_state});

        if (joy_load === 1'b0) begin
            chain_reg = word;
            chain_idx = 0;
        end else if (prev_clk === 1'b1 && joy_clk === 1'b0) begin
            chain_idx++;
        end
        prev_clk = joy_clk;
        joy_data = (chain_idx < NBITS) ? chain_reg[chain_idx] : 1'b1;
        if (ph == TICK - 1) m_scan_word = word;

        snap_req = snap_in;
        rst      = rst_in;

        if (rst_in) begin
            resetModel();
        end else begin
            if (exp_done) begin
`ifdef JOY_DEBOUNCE_EN
                if (m_prev_valid && m_scan_word == m_prev) begin
                    m_shadow       = m_scan_word;
                    m_shadow_valid = 1'b1;
                end
                m_prev       = m_scan_word;
                m_prev_valid = 1'b1;
`else
                m_shadow       = m_scan_word;
                m_shadow_valid = 1'b1;
`endif
            end
            if (m_pending || snap_in) begin
                if (m_shadow_valid) begin
                    m_state   = m_shadow;
                    m_valid   = 1'b1;
                    m_pending = 1'b0;
                end else begin
                    m_pending = 1'b1;
                end
            end
            m_c++;
        end
        @(negedge clk);
    endtask

    task automatic runTo(input int target);
        while (m_c < target) applyStimulus(1'b0, 1'b0);
    endtask

    task automatic checkResetValues(input string tag);
        checkOutput({tag, "_joy_load"}, 32'(joy_load), 32'd0);
        checkOutput({tag, "_joy_clk"}, 32'(joy_clk), 32'd0);
        checkOutput({tag, "_scan_done"}, 32'(scan_done), 32'd0);
        checkOutput({tag, "_joy_state"}, 32'(joy_state), 32'hFFFFFF);
        checkOutput({tag, "_joy_valid"}, 32'(joy_valid), 32'd0);
    endtask

    initial begin
        int load_low;
        int rises;
        int first_done;
        logic last_clk;

`ifdef JOY_DEBOUNCE_EN
        vecs[0] = '{24'h000001,   3,  -1, 24'hFFFFFF, 1'b0};
        vecs[1] = '{24'h000002,  -1,  -1, 24'hFFFFFF, 1'b0};
        vecs[2] = '{24'h000001,  -1,  -1, 24'hFFFFFF, 1'b0};
        vecs[3] = '{24'h000002,  -1,  -1, 24'hFFFFFF, 1'b0};
        vecs[4] = '{24'h000001,  -1,  -1, 24'hFFFFFF, 1'b0};
        vecs[5] = '{24'h000001,  -1,  -1, 24'hFFFFFF, 1'b0};
        vecs[6] = '{24'h0000FF,  -1,  -1, 24'h000001, 1'b1};
        vecs[7] = '{24'h0000FF,   3,  -1, 24'h000001, 1'b1};
        vecs[8] = '{24'h0000FF,  -1,  -1, 24'h000001, 1'b1};
        vecs[9] = '{24'h123456,   3,  -1, 24'h0000FF, 1'b1};
`else
        vecs[0] = '{24'hA53C0F,  20,  30, 24'hFFFFFF, 1'b0};
        vecs[1] = '{24'hFFFFFF,  -1,  -1, 24'hA53C0F, 1'b1};
        vecs[2] = '{24'hFFFFFE,   3,  -1, 24'hFFFFFF, 1'b1};
        vecs[3] = '{24'h0F0F0F,   0,  -1, 24'hFFFFFE, 1'b1};
        vecs[4] = '{24'h5A5A5A,  40,  50, 24'h0F0F0F, 1'b1};
        vecs[5] = '{24'h000000,  -1,  -1, 24'h0F0F0F, 1'b1};
        vecs[6] = '{24'h800001, 207,  -1, 24'h000000, 1'b1};
        vecs[7] = '{24'h123456,  -1,  -1, 24'h000000, 1'b1};
        vecs[8] = '{24'hFEDCBA,   0,  -1, 24'h123456, 1'b1};
        vecs[9] = '{24'h000001,  -1,  -1, 24'h123456, 1'b1};
`endif

        rst = 1'b1;
        repeat (2) @(negedge clk);
        resetModel();
        checkResetValues("reset");

        // First scan with the chain idle: strobe and shift-clock shape.
        load_low   = 0;
        rises      = 0;
        first_done = -1;
        last_clk   = 1'b0;
        for (int i = 0; i <= PER; i++) begin
            if (i < PER && joy_load === 1'b0) load_low++;
            if (i < PER && joy_clk === 1'b1 && last_clk === 1'b0) rises++;
            if (scan_done === 1'b1 && first_done < 0) first_done = i;
            last_clk = joy_clk;
            applyStimulus(1'b0, 1'b0);
        end
        checkOutput("load_low_cycles", 32'(load_low), 32'd8);
        checkOutput("joy_clk_pulses", 32'(rises), 32'd24);
        checkOutput("first_scan_done_cycle", 32'(first_done), 32'(PER));

        // Second scan carries a pattern; request it after its completion.
        word = 24'hA53C0F;
        runTo(2 * PER + 4);
        checkOutput("pre_publish_state", 32'(joy_state), 32'hFFFFFF);
        applyStimulus(1'b1, 1'b0);
`ifdef JOY_DEBOUNCE_EN
        checkOutput("publish_state", 32'(joy_state), 32'hFFFFFF);
        checkOutput("publish_valid", 32'(joy_valid), 32'd0);
`else
        checkOutput("publish_state", 32'(joy_state), 32'hA53C0F);
        checkOutput("publish_valid", 32'(joy_valid), 32'd1);
`endif

        // Reset during the high half of bit 12 of the third scan.
        word = 24'h777777;
        runTo(2 * PER + 2 * TICK + 12 * TICK + 5);
        applyStimulus(1'b0, 1'b1);
        checkResetValues("midscan_reset");

        for (int v = 0; v < 10; v++) begin
            word = vecs[v].word;
            for (int off = 0; off < PER; off++) begin
                applyStimulus((off == vecs[v].snap_a) || (off == vecs[v].snap_b), 1'b0);
            end
            checkOutput($sformatf("vec%0d_joy_state", v), 32'(joy_state), 32'(vecs[v].exp_state));
            checkOutput($sformatf("vec%0d_joy_valid", v), 32'(joy_valid), 32'(vecs[v].exp_valid));
        end

        // Random words (often repeated so debounce can accept), random requests and rare resets.
        for (int w = 0; w < 10; w++) begin
            if ($urandom_range(0, 2) != 0) word = NBITS'($urandom);
            for (int off = 0; off < PER; off++) begin
                applyStimulus($urandom_range(0, 60) == 0, $urandom_range(0, 1500) == 0);
            end
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/joy_scan_ctrl.md
# joy_scan_ctrl

Scan controller for the serial joystick chain: a cascade of parallel-in/serial-out shift registers holding both players' controls. It generates the chain's load strobe and shift clock from the system clock, and deserialises NBITS bits per scan into a shadow register. It then publishes a coherent, optionally debounced snapshot to the core only on a frame-aligned request. It sits between the board connector pins and the arcade core's input-port logic, replacing free-running decode with a sequenced, handshaked scan.

## Interface
Parameters:
- DIV_LOG2, 3: tick divider exponent; one tick every 2^DIV_LOG2 clk cycles (minimum 1).
- NBITS, 24: bits shifted per scan (1..32).

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  reset; the only reset, synchronous, active-high.
- joy_data  in  1  serial data from the chain; active-low buttons.
- joy_load  out  1  parallel-load strobe to the chain; active-low.
- joy_clk  out  1  shift clock to the chain.
- snap_req  in  1  one-cycle frame-boundary pulse, e.g. vblank start.
- joy_state  out  NBITS  published snapshot; bit k = k-th bit shifted in; active-low.
- joy_valid  out  1  high once at least one snapshot has been published since reset.
- scan_done  out  1  one-cycle pulse when a scan completes.

## Operation
- Tick generator: free-running counter cnt[DIV_LOG2-1:0]; tick = (cnt == all ones), one clk wide.
- FSM states advance only on tick:
  - LOAD: joy_load = 0 for the whole tick period.
  - SETTLE: joy_load = 1, joy_clk = 0.
  - SHIFT: joy_clk = cnt[DIV_LOG2-1], giving a low half then a high half per bit.
- Sampling: joy_data is sampled on the tick at the end of each SHIFT period. It is written to raw[bit_idx], then bit_idx increments.
- SHIFT exits after bit_idx = NBITS-1 is sampled. The FSM goes to LOAD and raises scan_done on the next cycle. Scans are continuous.
- On scan completion, raw is copied to shadow (subject to JOY_DEBOUNCE_EN).
- snap_req sets a pending flag. When pending is set and shadow is valid, shadow is copied to joy_state, joy_valid is set and pending is cleared.
- If snap_req and a scan completion land in the same cycle, the snapshot published is the scan just completed.
- A snap_req arriving while pending is already set is absorbed; at most one publish happens per pending.
- A snap_req before the first valid shadow stays pending until that shadow exists.
- joy_state changes only on a publish cycle. It never mixes bits from two scans.

## Timing
- Reset values:
  - State = LOAD, cnt = 0, bit_idx = 0.
  - joy_load = 0, joy_clk = 0, scan_done = 0.
  - raw, shadow and joy_state = all ones; joy_valid = 0; pending = 0.
- Scan period = (NBITS+2) ticks = (NBITS+2)·2^DIV_LOG2 clk. Defaults give 208 clk.
- The first scan_done after reset release comes (NBITS+2)·2^DIV_LOG2 cycles later.
- Publish latency: joy_state updates 1 clk after the cycle where pending and a valid shadow coincide.
- Reset asserted mid-scan discards the partial raw and shadow, clears pending, and restarts at LOAD on the next cycle.
- joy_clk holds 0 outside SHIFT. joy_load holds 1 outside LOAD.

## Configuration
- JOY_DEBOUNCE_EN defined:
  - A completed scan is copied to shadow only if it equals the previous completed scan (prev_raw register).
  - Shadow first becomes valid after two identical consecutive scans.
- JOY_DEBOUNCE_EN undefined:
  - Every completed scan is copied to shadow.
  - Shadow is valid after the first scan.
  - No prev_raw register is built.

## Structure
- Package joy_pkg holds:
  - The FSM state enum (LOAD, SETTLE, SHIFT).
  - Bit-index constants for the default 24-bit map: P1 start=0, fire3=1, fire2=2, fire1=3, right=4, left=5, down=6, up=7, then the same order for P2 at 8..15, then P2 select, test, P2 coin, P2 fire4, P1 select, service, P1 coin, P1 fire4 at 16..23.
- One sub-module, joy_tick_gen, contains the divider counter and produces tick and phase (cnt MSB).

## Test plan
- Reset then release, with joy_data tied 1:
  - joy_load is low for exactly 8 clk.
  - 24 joy_clk pulses follow, each 4 clk low then 4 clk high.
  - scan_done fires at cycle 208.
- Shift model loaded with 24'hA5_3C_0F, then snap_req after the first scan_done → joy_state = 24'hA5_3C_0F one clk later and joy_valid = 1.
- snap_req in the same cycle as scan_done, with the model changing from 24'hFFFFFF to 24'hFFFFFE → the new value 24'hFFFFFE is published.
- Two snap_req pulses 10 clk apart with no scan_done between them → exactly one publish, and joy_state is stable afterwards.
- rst asserted at bit 12 of a scan → all outputs return to reset values next cycle; the next full scan publishes correctly on request.
- JOY_DEBOUNCE_EN with the model alternating between 24'h000001 and 24'h000002 every scan → joy_state stays 24'hFFFFFF. Two matching scans of 24'h000001 → 24'h000001 is published on the next request.
